// File: rtl/axi4_pkg.sv
// AXI4 encodings shared by the DMA read path.
package axi4_pkg;

    localparam int BURST_BITS = 2;
    localparam int SIZE_BITS  = 3;

    localparam logic [BURST_BITS-1:0] BURST_FIXED = 2'd0;
    localparam logic [BURST_BITS-1:0] BURST_INCR  = 2'd1;

    localparam logic [1:0] RESP_OKAY = 2'd0;

endpackage

// File: rtl/dmac_pkg.sv
// DMA controller shared types: read-initiator state encoding and AXI page geometry.
package dmac_pkg;

    localparam int unsigned PAGE_BYTES       = 4096;
    localparam int unsigned PAGE_OFFSET_BITS = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT_BUF,
        ST_ADDR,
        ST_DATA
    } dmac_state_e;

endpackage

// File: rtl/dmac_read_initiator_if.sv
// AXI4 read-address and read-data channels between the DMA read initiator and memory.
interface dmac_read_initiator_if #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32
);

    logic               arvalid;
    logic [ADDR_WD-1:0] araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arready;
    logic               rvalid;
    logic [DATA_WD-1:0] rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rready;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );

endinterface

// File: rtl/dmac_burst_calc.sv
// Beat count for the next burst: remaining beats, capped by the burst limit and,
// for INCR bursts, by the room left before the next 4 KiB page boundary.
module dmac_burst_calc
    import axi4_pkg::*;
    import dmac_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [ADDR_WD-1:0]                addr,
    input  logic [ADDR_WD-1:0]                length,
    input  logic [SIZE_BITS-1:0]              size,
    input  logic [BURST_BITS-1:0]             burst,
    output logic [$clog2(MAX_BURST_LEN)+1:0]  beats
);

    localparam int CNT_WD = $clog2(MAX_BURST_LEN) + 2;
    localparam int PW     = PAGE_OFFSET_BITS + 1;

    logic [ADDR_WD-1:0] total_beats;
    logic [ADDR_WD-1:0] limit;
    logic [PW-1:0]      page_bytes;
    logic [PW-1:0]      page_beats;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^addr[ADDR_WD-1:PAGE_OFFSET_BITS];

    // A misaligned start address can leave less than one beat of room; still issue one beat
    // so a non-empty request always makes progress.
    always_comb begin
        total_beats = length >> size;
        page_bytes  = PW'(PAGE_BYTES) - {1'b0, addr[PAGE_OFFSET_BITS-1:0]};
        page_beats  = page_bytes >> size;
        if (page_beats == '0) begin
            page_beats = PW'(1);
        end
        limit = ADDR_WD'(MAX_BURST_LEN);
        if ((burst == BURST_INCR) && (ADDR_WD'(page_beats) < limit)) begin
            limit = ADDR_WD'(page_beats);
        end
        beats = (total_beats < limit) ? total_beats[CNT_WD-1:0] : limit[CNT_WD-1:0];
    end

endmodule

// File: rtl/dmac_read_initiator.sv
// DMA read initiator: turns one channel read request into a single AXI4 read burst,
// reserves buffer space, streams the beats out and reports response errors per burst.
module dmac_read_initiator
    import axi4_pkg::*;
    import dmac_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int CHANNEL_COUNT = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              rd_req_valid,
    input  logic [$clog2(CHANNEL_COUNT)-1:0]  rd_req_channel,
    input  logic [ADDR_WD-1:0]                rd_req_addr,
    input  logic [BURST_BITS-1:0]             rd_req_burst,
    input  logic [ADDR_WD-1:0]                rd_req_length,
    input  logic [SIZE_BITS-1:0]              rd_req_size,

    output logic                              rd_req_ack,
    output logic [ADDR_WD-1:0]                rd_req_next_addr,
    output logic [ADDR_WD-1:0]                rd_req_next_length,
    output logic                              rd_req_done,

    input  logic [$clog2(MAX_BURST_LEN)+1:0]  buf_free_count,
    output logic                              buf_inc_usage_valid,
    output logic [$clog2(MAX_BURST_LEN)+1:0]  buf_inc_usage_count,
    output logic                              data_out_valid,
    input  logic                              data_out_ready,
    output logic [DATA_WD-1:0]                data_out,
    output logic                              data_out_last,

    output logic                              rd_err_valid,
    output logic [$clog2(CHANNEL_COUNT)-1:0]  rd_err_channel,

    dmac_read_initiator_if.master             m_axi
);

    localparam int CH_WD  = $clog2(CHANNEL_COUNT);
    localparam int CNT_WD = $clog2(MAX_BURST_LEN) + 2;

    dmac_state_e           state_q, state_d;
    logic [ADDR_WD-1:0]    addr_q, addr_d;
    logic [ADDR_WD-1:0]    length_q, length_d;
    logic [SIZE_BITS-1:0]  size_q, size_d;
    logic [BURST_BITS-1:0] burst_q, burst_d;
    logic [CH_WD-1:0]      channel_q, channel_d;
    logic [CNT_WD-1:0]     beats_q, beats_d;
    logic [CNT_WD-1:0]     beat_cnt_q, beat_cnt_d;
    logic                  arvalid_q, arvalid_d;
    logic                  err_flag_q, err_flag_d;
    logic                  err_valid_q, err_valid_d;
    logic [CH_WD-1:0]      err_channel_q, err_channel_d;

    logic [CNT_WD-1:0]     calc_beats;
    logic [ADDR_WD-1:0]    burst_bytes;
    logic [ADDR_WD-1:0]    next_length;
    logic                  in_data;
    logic                  zero_req;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  last_beat;
    logic                  beat_err;

    dmac_burst_calc #(
        .ADDR_WD       (ADDR_WD),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .addr   (addr_q),
        .length (length_q),
        .size   (size_q),
        .burst  (burst_q),
        .beats  (calc_beats)
    );

    // Handshake qualifiers and the request response; the response fields are only
    // meaningful while rd_req_ack is high and are held at zero otherwise.
    always_comb begin
        in_data     = (state_q == ST_DATA);
        zero_req    = (state_q == ST_CALC) && (calc_beats == '0);
        ar_hs       = arvalid_q && m_axi.arready;
        r_hs        = in_data && m_axi.rvalid && data_out_ready;
        last_beat   = (beat_cnt_q == beats_q - CNT_WD'(1));
        beat_err    = (m_axi.rresp != RESP_OKAY) || (m_axi.rlast != last_beat);
        burst_bytes = ADDR_WD'(beats_q) << size_q;
        next_length = length_q - burst_bytes;

        rd_req_ack         = zero_req || ar_hs;
        rd_req_done        = zero_req || (ar_hs && (next_length == '0));
        rd_req_next_addr   = '0;
        rd_req_next_length = '0;
        if (zero_req) begin
            rd_req_next_addr = addr_q;
        end else if (ar_hs) begin
            rd_req_next_addr   = (burst_q == BURST_FIXED) ? addr_q : addr_q + burst_bytes;
            rd_req_next_length = next_length;
        end

        buf_inc_usage_valid = ar_hs;
        buf_inc_usage_count = ar_hs ? beats_q : '0;
        data_out_valid      = in_data && m_axi.rvalid;
        data_out            = m_axi.rdata;
        data_out_last       = in_data && last_beat;
    end

    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = 8'(beats_q - CNT_WD'(1));
    assign m_axi.arsize  = size_q;
    assign m_axi.arburst = burst_q;
    assign m_axi.rready  = in_data && data_out_ready;

    assign rd_err_valid   = err_valid_q;
    assign rd_err_channel = err_channel_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        length_d      = length_q;
        size_d        = size_q;
        burst_d       = burst_q;
        channel_d     = channel_q;
        beats_d       = beats_q;
        beat_cnt_d    = beat_cnt_q;
        arvalid_d     = arvalid_q;
        err_flag_d    = err_flag_q;
        err_valid_d   = 1'b0;
        err_channel_d = err_channel_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_req_valid) begin
                    addr_d    = rd_req_addr;
                    length_d  = rd_req_length;
                    size_d    = rd_req_size;
                    burst_d   = rd_req_burst;
                    channel_d = rd_req_channel;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                beats_d = calc_beats;
                state_d = (calc_beats == '0) ? ST_IDLE : ST_WAIT_BUF;
            end
            ST_WAIT_BUF: begin
                if (buf_free_count >= beats_q) begin
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = '0;
                    err_flag_d = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + CNT_WD'(1);
                    err_flag_d = err_flag_q || beat_err;
                    // The error pulse covers the final beat itself, so fold its status in directly.
                    if (last_beat) begin
                        beat_cnt_d    = '0;
                        err_flag_d    = 1'b0;
                        err_valid_d   = err_flag_q || beat_err;
                        err_channel_d = channel_q;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            length_q      <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            channel_q     <= '0;
            beats_q       <= '0;
            beat_cnt_q    <= '0;
            arvalid_q     <= 1'b0;
            err_flag_q    <= 1'b0;
            err_valid_q   <= 1'b0;
            err_channel_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            length_q      <= length_d;
            size_q        <= size_d;
            burst_q       <= burst_d;
            channel_q     <= channel_d;
            beats_q       <= beats_d;
            beat_cnt_q    <= beat_cnt_d;
            arvalid_q     <= arvalid_d;
            err_flag_q    <= err_flag_d;
            err_valid_q   <= err_valid_d;
            err_channel_q <= err_channel_d;
        end
    end

endmodule

// File: tb/tb_dmac_read_initiator.sv
// Directed bench for dmac_read_initiator: page splitting, buffer back-pressure, beat streaming,
// error reporting, mid-burst reset and zero-length requests against hand-computed values.
module tb_dmac_read_initiator;

    logic        clk;
    logic        rst;
    logic        rd_req_valid;
    logic [2:0]  rd_req_channel;
    logic [31:0] rd_req_addr;
    logic [1:0]  rd_req_burst;
    logic [31:0] rd_req_length;
    logic [2:0]  rd_req_size;
    logic        rd_req_ack;
    logic [31:0] rd_req_next_addr;
    logic [31:0] rd_req_next_length;
    logic        rd_req_done;
    logic [5:0]  buf_free_count;
    logic        buf_inc_usage_valid;
    logic [5:0]  buf_inc_usage_count;
    logic        data_out_valid;
    logic        data_out_ready;
    logic [31:0] data_out;
    logic        data_out_last;
    logic        rd_err_valid;
    logic [2:0]  rd_err_channel;

    int compared   = 0;
    int mismatched = 0;

    dmac_read_initiator_if #(.ADDR_WD(32), .DATA_WD(32)) axi_if ();

    dmac_read_initiator #(
        .ADDR_WD       (32),
        .DATA_WD       (32),
        .CHANNEL_COUNT (8),
        .MAX_BURST_LEN (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rd_req_valid        (rd_req_valid),
        .rd_req_channel      (rd_req_channel),
        .rd_req_addr         (rd_req_addr),
        .rd_req_burst        (rd_req_burst),
        .rd_req_length       (rd_req_length),
        .rd_req_size         (rd_req_size),
        .rd_req_ack          (rd_req_ack),
        .rd_req_next_addr    (rd_req_next_addr),
        .rd_req_next_length  (rd_req_next_length),
        .rd_req_done         (rd_req_done),
        .buf_free_count      (buf_free_count),
        .buf_inc_usage_valid (buf_inc_usage_valid),
        .buf_inc_usage_count (buf_inc_usage_count),
        .data_out_valid      (data_out_valid),
        .data_out_ready      (data_out_ready),
        .data_out            (data_out),
        .data_out_last       (data_out_last),
        .rd_err_valid        (rd_err_valid),
        .rd_err_channel      (rd_err_channel),
        .m_axi               (axi_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_arvalid"}, 64'(axi_if.arvalid), 64'(0));
        checkOutput({tag, "_rready"}, 64'(axi_if.rready), 64'(0));
        checkOutput({tag, "_dvalid"}, 64'(data_out_valid), 64'(0));
        checkOutput({tag, "_dlast"}, 64'(data_out_last), 64'(0));
        checkOutput({tag, "_ack"}, 64'(rd_req_ack), 64'(0));
        checkOutput({tag, "_done"}, 64'(rd_req_done), 64'(0));
        checkOutput({tag, "_inc"}, 64'(buf_inc_usage_valid), 64'(0));
        checkOutput({tag, "_err"}, 64'(rd_err_valid), 64'(0));
    endtask

    // One request presented in IDLE; on return the DUT sits in CALC.
    task automatic applyStimulus(input logic [2:0] ch, input logic [31:0] addr, input logic [31:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
        rd_req_channel = ch;
        rd_req_addr    = addr;
        rd_req_length  = len;
        rd_req_size    = size;
        rd_req_burst   = burst;
        rd_req_valid   = 1'b1;
        tick();
        rd_req_valid   = 1'b0;
    endtask

    task automatic doAr(input logic [31:0] exp_addr, input logic [7:0] exp_len, input logic [2:0] exp_size,
                        input logic [1:0] exp_burst, input logic [31:0] exp_next_addr,
                        input logic [31:0] exp_next_len, input logic exp_done);
        for (int k = 0; k < 20 && axi_if.arvalid !== 1'b1; k++) tick();
        checkOutput("ar_valid", 64'(axi_if.arvalid), 64'(1));
        checkOutput("ar_addr", 64'(axi_if.araddr), 64'(exp_addr));
        checkOutput("ar_len", 64'(axi_if.arlen), 64'(exp_len));
        checkOutput("ar_size", 64'(axi_if.arsize), 64'(exp_size));
        checkOutput("ar_burst", 64'(axi_if.arburst), 64'(exp_burst));
        checkOutput("ack_before_ready", 64'(rd_req_ack), 64'(0));
        axi_if.arready = 1'b1;
        #1;
        checkOutput("ack", 64'(rd_req_ack), 64'(1));
        checkOutput("inc_valid", 64'(buf_inc_usage_valid), 64'(1));
        checkOutput("inc_count", 64'(buf_inc_usage_count), 64'(exp_len) + 64'(1));
        checkOutput("next_addr", 64'(rd_req_next_addr), 64'(exp_next_addr));
        checkOutput("next_length", 64'(rd_req_next_length), 64'(exp_next_len));
        checkOutput("done", 64'(rd_req_done), 64'(exp_done));
        tick();
        axi_if.arready = 1'b0;
        checkOutput("arvalid_drop", 64'(axi_if.arvalid), 64'(0));
    endtask

    // Streams n beats; optional error beat, 50% ready toggling, reset on a beat, new request on the last beat.
    task automatic serveBeats(input int n, input int err_beat, input bit toggle, input int rst_beat,
                              input bit req_on_last);
        for (int i = 0; i < n; i++) begin
            axi_if.rvalid = 1'b1;
            axi_if.rdata  = 32'hA500_0000 + 32'(i);
            axi_if.rresp  = (i == err_beat) ? 2'd2 : 2'd0;
            axi_if.rlast  = (i == n - 1);
            if (toggle) begin
                data_out_ready = 1'b0;
                #1;
                checkOutput("rready_low", 64'(axi_if.rready), 64'(0));
                checkOutput("held_valid", 64'(data_out_valid), 64'(1));
                checkOutput("held_data", 64'(data_out), 64'(32'hA500_0000 + 32'(i)));
                tick();
            end
            data_out_ready = 1'b1;
            if (req_on_last && i == n - 1) rd_req_valid = 1'b1;
            #1;
            checkOutput("rready_high", 64'(axi_if.rready), 64'(1));
            checkOutput("beat_valid", 64'(data_out_valid), 64'(1));
            checkOutput("beat_data", 64'(data_out), 64'(32'hA500_0000 + 32'(i)));
            checkOutput($sformatf("beat_last_%0d", i), 64'(data_out_last), 64'(i == n - 1));
            if (i == rst_beat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                return;
            end
            tick();
        end
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
        axi_if.rresp  = 2'd0;
    endtask

    initial begin
        rst            = 1'b1;
        rd_req_valid   = 1'b0;
        rd_req_channel = '0;
        rd_req_addr    = '0;
        rd_req_burst   = 2'd1;
        rd_req_length  = '0;
        rd_req_size    = '0;
        buf_free_count = 6'd16;
        data_out_ready = 1'b1;
        axi_if.arready = 1'b0;
        axi_if.rvalid  = 1'b0;
        axi_if.rdata   = '0;
        axi_if.rresp   = 2'd0;
        axi_if.rlast   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkQuiet("reset");

        $display("[TB] 16-beat INCR burst at 0x1000");
        applyStimulus(3'd1, 32'h1000, 32'd64, 3'd2, 2'd1);
        doAr(32'h1000, 8'd15, 3'd2, 2'd1, 32'h1040, 32'd0, 1'b1);
        serveBeats(16, -1, 1'b0, -1, 1'b0);
        checkOutput("t1_no_err", 64'(rd_err_valid), 64'(0));

        $display("[TB] burst split at the 4 KiB boundary");
        applyStimulus(3'd2, 32'h0FF8, 32'd64, 3'd2, 2'd1);
        doAr(32'h0FF8, 8'd1, 3'd2, 2'd1, 32'h1000, 32'd56, 1'b0);
        serveBeats(2, -1, 1'b0, -1, 1'b0);
        checkOutput("t2_no_err", 64'(rd_err_valid), 64'(0));

        $display("[TB] buffer back-pressure then ready toggling");
        buf_free_count = 6'd4;
        applyStimulus(3'd3, 32'h2000, 32'd64, 3'd2, 2'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            checkOutput("wait_buf_arvalid", 64'(axi_if.arvalid), 64'(0));
            tick();
        end
        buf_free_count = 6'd16;
        tick();
        checkOutput("wait_buf_exit", 64'(axi_if.arvalid), 64'(1));
        doAr(32'h2000, 8'd15, 3'd2, 2'd1, 32'h2040, 32'd0, 1'b1);
        serveBeats(16, -1, 1'b1, -1, 1'b0);
        checkOutput("t3_no_err", 64'(rd_err_valid), 64'(0));

        $display("[TB] SLVERR on beat 3, channel 5");
        applyStimulus(3'd5, 32'h3000, 32'd64, 3'd2, 2'd1);
        doAr(32'h3000, 8'd15, 3'd2, 2'd1, 32'h3040, 32'd0, 1'b1);
        serveBeats(16, 2, 1'b0, -1, 1'b0);
        checkOutput("err_valid", 64'(rd_err_valid), 64'(1));
        checkOutput("err_channel", 64'(rd_err_channel), 64'(5));
        tick();
        checkOutput("err_pulse_end", 64'(rd_err_valid), 64'(0));

        $display("[TB] FIXED burst not page limited, request arriving on final beat");
        applyStimulus(3'd4, 32'h0FFC, 32'd128, 3'd2, 2'd0);
        doAr(32'h0FFC, 8'd15, 3'd2, 2'd0, 32'h0FFC, 32'd64, 1'b0);
        rd_req_channel = 3'd7;
        rd_req_addr    = 32'h6000;
        rd_req_length  = 32'd0;
        rd_req_size    = 3'd2;
        rd_req_burst   = 2'd1;
        serveBeats(16, -1, 1'b0, -1, 1'b1);
        checkOutput("t5_no_err", 64'(rd_err_valid), 64'(0));
        checkOutput("late_req_not_taken", 64'(rd_req_ack), 64'(0));
        tick();
        rd_req_valid = 1'b0;
        checkOutput("late_req_ack", 64'(rd_req_ack), 64'(1));
        checkOutput("late_req_done", 64'(rd_req_done), 64'(1));
        checkOutput("late_req_next_addr", 64'(rd_req_next_addr), 64'(32'h6000));
        tick();

        $display("[TB] reset in the middle of a burst");
        applyStimulus(3'd6, 32'h4000, 32'd64, 3'd2, 2'd1);
        doAr(32'h4000, 8'd15, 3'd2, 2'd1, 32'h4040, 32'd0, 1'b1);
        serveBeats(16, 4, 1'b0, 7, 1'b0);
        checkQuiet("midreset");
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
        axi_if.rresp  = 2'd0;
        tick();
        checkOutput("midreset_no_err", 64'(rd_err_valid), 64'(0));

        $display("[TB] zero-length request");
        applyStimulus(3'd2, 32'h5000, 32'd0, 3'd2, 2'd1);
        checkOutput("zero_ack", 64'(rd_req_ack), 64'(1));
        checkOutput("zero_done", 64'(rd_req_done), 64'(1));
        checkOutput("zero_next_addr", 64'(rd_req_next_addr), 64'(32'h5000));
        checkOutput("zero_next_length", 64'(rd_req_next_length), 64'(0));
        checkOutput("zero_arvalid", 64'(axi_if.arvalid), 64'(0));
        checkOutput("zero_inc", 64'(buf_inc_usage_valid), 64'(0));
        tick();
        checkOutput("zero_ack_end", 64'(rd_req_ack), 64'(0));
        checkOutput("zero_idle_arvalid", 64'(axi_if.arvalid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
